// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, execute FSM encoding and the mul funct
// field that the ALU control decoder also matches on.
package alu_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b100;
   localparam logic [2:0] ALU_OR  = 3'b101;
   localparam logic [2:0] ALU_MUL = 3'b111;

   localparam logic [5:0] MUL_FUNCT = 6'b011000;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } state_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier datapath: one partial product per step, low WIDTH
// bits only. Sequencing is owned by alu_exec.
module mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] acc_next,
   output logic             last
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] mcand, mplier, acc;
   logic [CW-1:0]    cnt;

   // acc_next includes the current step so the final step's sum can be captured directly
   assign acc_next = acc + (mplier[0] ? mcand : '0);
   assign last     = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
      end else if (load) begin
         mcand  <= a;
         mplier <= b;
         acc    <= '0;
         cnt    <= '0;
      end else if (step) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/alu_exec.sv
// Execution-stage ALU: single-cycle add/sub/and/or, iterative multiply with busy stall.
// Multiply is built only when ALU_EXEC_MUL_EN is defined; otherwise code 111 yields 0.
module alu_exec
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [2:0]       ALU_Ctrl_i,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   output logic [WIDTH-1:0] data_o,
   output logic             zero_o,
   output logic             busy_o,
   output logic             done_o
);

   state_t           state;
   logic [WIDTH-1:0] op_res;

   always_comb begin
      op_res = '0;
      case (ALU_Ctrl_i)
         ALU_ADD: op_res = data1_i + data2_i;
         ALU_SUB: op_res = data1_i - data2_i;
         ALU_AND: op_res = data1_i & data2_i;
         ALU_OR:  op_res = data1_i | data2_i;
         default: op_res = '0;
      endcase
   end

`ifdef ALU_EXEC_MUL_EN
   logic             mul_load, mul_last;
   logic [WIDTH-1:0] mul_acc;

   assign mul_load = (state == IDLE) && start_i && (ALU_Ctrl_i == ALU_MUL);
   assign busy_o   = (state == MUL);

   mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .load     (mul_load),
      .step     (busy_o),
      .a        (data1_i),
      .b        (data2_i),
      .acc_next (mul_acc),
      .last     (mul_last)
   );
`else
   assign busy_o = 1'b0;
`endif

   assign zero_o = (data_o == '0);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state  <= IDLE;
         data_o <= '0;
         done_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: if (start_i) begin
`ifdef ALU_EXEC_MUL_EN
               if (ALU_Ctrl_i == ALU_MUL) begin
                  state <= MUL;
               end else begin
                  data_o <= op_res;
                  done_o <= 1'b1;
               end
`else
               data_o <= op_res;
               done_o <= 1'b1;
`endif
            end
`ifdef ALU_EXEC_MUL_EN
            MUL: if (mul_last) begin
               data_o <= mul_acc;
               done_o <= 1'b1;
               state  <= IDLE;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/alu_exec.md
# alu_exec

Execution-stage ALU that consumes the 3-bit ALU control code produced by the ALU control decoder and performs the selected operation on two 32-bit operands. Add, sub, and, and or complete in one cycle. Multiply (code 3'b111) runs as an iterative 32-cycle shift-add operation, with a busy indication that the pipeline uses as a stall source. The block sits between the ID/EX register and the EX/MEM register.

## Interface
Parameters:
- WIDTH, 32, operand and result width; the multiply iteration count equals WIDTH.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- start_i  input  1  operation request; sampled only when busy_o is 0.
- ALU_Ctrl_i  input  3  operation code: 000 add, 010 sub, 100 and, 101 or, 111 mul; 001, 011 and 110 are unused.
- data1_i  input  WIDTH  operand A.
- data2_i  input  WIDTH  operand B.
- data_o  output  WIDTH  registered result; holds its value until the next operation completes.
- zero_o  output  1  high when data_o equals 0; combinational from data_o.
- busy_o  output  1  high while a multiply is in progress; drives the pipeline stall.
- done_o  output  1  one-cycle pulse marking the cycle in which data_o carries a new result.

## Operation
- Reset values: data_o = 0, zero_o = 1, busy_o = 0, done_o = 0, FSM = IDLE, internal iteration registers = 0.
- FSM states and transitions:
  - IDLE:
    - start_i = 1 with a single-cycle code: write data_o, pulse done_o, stay in IDLE.
    - start_i = 1 with code 111: load the multiplicand (A), the multiplier (B), acc = 0 and cnt = 0, then go to MUL.
  - MUL, one step per cycle:
    - if multiplier[0] = 1, acc += multiplicand;
    - multiplicand shifts left by 1; multiplier shifts right by 1; cnt increments.
    - In the step where cnt = WIDTH-1: data_o gets the final acc, done_o pulses, FSM returns to IDLE.
- Arithmetic rules:
  - add and sub wrap modulo 2^WIDTH; no overflow flag.
  - and and or are bitwise.
  - mul returns the low WIDTH bits of the product, which are identical for signed and unsigned operands.
- Unused codes: data_o = 0 and done_o pulses, with single-cycle timing.
- start_i is ignored while busy_o = 1. The operands and code captured at acceptance are used; later changes to the inputs have no effect on the multiply in progress.
- Reset asserted mid-multiply: the multiply is aborted and all outputs return to their reset values immediately. No done_o is produced for the aborted operation.

## Timing
- Single-cycle op accepted at edge E: data_o and done_o = 1 are valid after E, so latency is 1.
- Multiply accepted at edge E:
  - busy_o is high from after E through after E+31 (32 cycles).
  - Result and done_o = 1 appear after E+32; busy_o is low in that same cycle.
- Back-to-back: a new start_i is accepted in the cycle where done_o = 1. Single-cycle ops sustain one result per cycle.
- done_o is never high for two consecutive cycles unless two operations were accepted on consecutive edges.

## Configuration
- ALU_EXEC_MUL_EN defined: code 111 runs the iterative multiply as described.
- ALU_EXEC_MUL_EN undefined:
  - code 111 is handled as an unused code (data_o = 0, single cycle);
  - the MUL state and the iteration registers are removed;
  - busy_o is tied to 0.

## Structure
- Shared package alu_pkg:
  - control-code constants ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_MUL;
  - the FSM state encoding (IDLE, MUL);
  - the MUL_FUNCT constant 6'b011000, which the decoder also uses.
- Sub-module mul_iter: holds the multiplicand, multiplier, accumulator and counter; has load/step inputs and a last-step output. It is instantiated only under ALU_EXEC_MUL_EN. alu_exec owns the FSM and the output registers.

## Test plan
- Reset release, then add 5 + 7 -> after one edge data_o = 12, done_o = 1 for one cycle, zero_o = 0.
- sub 3 - 3 -> data_o = 0, zero_o = 1; sub 0 - 1 -> data_o = 32'hFFFFFFFF.
- and / or with 32'hF0F0_00FF and 32'h0FF0_0F0F -> data_o = 32'h00F0_000F, then 32'hFFF0_0FFF.
- mul 32'hFFFFFFFF × 32'h00000003 -> busy_o high for exactly 32 cycles, then data_o = 32'hFFFFFFFD with done_o; start_i pulses during busy_o are ignored.
- Multiply started, reset asserted at cycle 10 -> data_o = 0 and busy_o = 0 immediately. After release, add 1 + 1 gives 2 with latency 1.
- ALU_EXEC_MUL_EN undefined: code 111 with operands 6 and 7 -> data_o = 0 after one edge, busy_o never asserts.
